// File: rtl/hpsfpga_led_pio.sv
// LED output PIO on the HPS lightweight bridge: data, atomic set/clear
// and a free-running per-bit blink engine, one-cycle registered readdata.
module hpsfpga_led_pio #(
  parameter int unsigned WIDTH       = 10,
  parameter logic [31:0] RESET_VALUE = 32'd0,
  parameter logic [31:0] BLINK_DIV   = 32'd50_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [WIDTH-1:0] RV =
    RESET_VALUE[WIDTH-1:0];
  localparam logic [31:0] DIV_M1 =
    BLINK_DIV - 32'd1;

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_mask;
  logic [31:0]      r_cnt;
  logic             r_phase;
  logic [WIDTH-1:0] r_out;
  logic [31:0]      r_rd;

  logic             w_wr;
  logic             w_mask_wr;
  logic             w_wrap;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_data_nxt;
  logic [31:0]      w_rd_nxt;

  assign w_wr      = chipselect & ~write_n;
  assign w_mask_wr = w_wr & (address == 2'd1);
  assign w_wrap    = (r_cnt == DIV_M1);
  assign w_wd      = writedata[WIDTH-1:0];

  always_comb begin
    w_data_nxt = r_data;
    if (w_wr) begin
      unique case (address)
        2'd0: w_data_nxt = w_wd;
        2'd1: w_data_nxt = r_data;
        2'd2: w_data_nxt = r_data | w_wd;
        2'd3: w_data_nxt = r_data & ~w_wd;
      endcase
    end
  end

  always_comb begin
    w_rd_nxt = 32'd0;
    unique case (address)
      2'd0:    w_rd_nxt = 32'(r_data);
      2'd1:    w_rd_nxt = 32'(r_mask);
      default: w_rd_nxt = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data <= RV;
      r_mask <= '0;
    end else begin
      r_data <= w_data_nxt;
      if (w_mask_wr)
        r_mask <= w_wd;
    end
  end

  // a mask write restarts the pattern and wins over a wrap
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_mask_wr) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_wrap) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out <= RV;
      r_rd  <= '0;
    end else begin
      r_out <= r_data ^ (r_mask & {WIDTH{r_phase}});
      r_rd  <= w_rd_nxt;
    end
  end

  assign out_port = r_out;
  assign readdata = r_rd;

endmodule
